// File: rtl/me_result_serializer.sv
// ME core output stage: buffers packed search results in a small FIFO and
// sends each one as a framed serial word (start=1, data LSB-first, stop=0).
module me_result_serializer #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  serial20,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned CYW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CYW-1:0] CYC_LAST   = CYW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_nxt;
    logic [CYW-1:0]        cyc_cnt;
    logic [CYW-1:0]        cyc_cnt_nxt;
    logic                  serial_nxt;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic                  fifo_nonempty;

    assign flush         = rst | init;
    assign in_ready      = !flush && (count != COUNT_FULL);
    assign push          = in_valid & in_ready;
    assign fifo_nonempty = (count != '0);
    assign bit_end       = (cyc_cnt == CYC_LAST);
    assign busy          = (state != IDLE) || fifo_nonempty;

    // FIFO storage; writes only on an accepted handshake
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Next-state, next serial bit and FIFO pop decision
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        cyc_cnt_nxt = bit_end ? '0 : cyc_cnt + 1'b1;
        serial_nxt  = 1'b0;
        pop         = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                cyc_cnt_nxt = '0;
                if (fifo_nonempty) begin
                    pop        = 1'b1;
                    shreg_nxt  = mem[rd_ptr];
                    state_nxt  = START;
                    serial_nxt = 1'b1;
                end
            end
            START: begin
                serial_nxt = 1'b1;
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    serial_nxt  = shreg[0];
                end
            end
            DATA: begin
                serial_nxt = shreg[0];
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt  = STOP;
                        serial_nxt = 1'b0;
                    end else begin
                        shreg_nxt   = shreg >> 1;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        serial_nxt  = shreg_nxt[0];
                    end
                end
            end
            STOP: begin
                serial_nxt = 1'b0;
                if (bit_end) begin
                    frame_done = !flush;
                    // Back-to-back: reload at the stop edge so no idle cycle appears
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        shreg_nxt  = mem[rd_ptr];
                        state_nxt  = START;
                        serial_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, FIFO pointers and the registered pad output
    always_ff @(posedge clk) begin
        if (flush) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            serial20 <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            cyc_cnt  <= cyc_cnt_nxt;
            serial20 <= serial_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_me_result_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a frame-schedule model (each accepted word gets a start edge).
module tb_me_result_serializer;

    logic        clk;
    logic        rst;
    logic        init;
    logic        v1;
    logic        v4;
    logic [19:0] din;
    logic        rdy1, rdy4;
    logic        ser1, ser4;
    logic        busy1, busy4;
    logic        fd1, fd4;

    me_result_serializer dut (
        .clk(clk), .rst(rst), .init(init), .in_valid(v1), .in_data(din),
        .in_ready(rdy1), .serial20(ser1), .busy(busy1), .frame_done(fd1)
    );

    me_result_serializer #(.BIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .init(init), .in_valid(v4), .in_data(din),
        .in_ready(rdy4), .serial20(ser4), .busy(busy4), .frame_done(fd4)
    );

    int checks = 0;
    int errors = 0;
    int t      = 0;
    int mb     = 1;
    bit sel4   = 0;

    // Model: one entry per accepted word
    int          m_acc[$];
    int          m_start[$];
    logic [19:0] m_word[$];
    int          last_end = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        t = t + 1;
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < m_word.size(); i++)
            if (m_acc[i] <= t && m_start[i] > t) n++;
        return n;
    endfunction

    task automatic step(input logic v, input logic [19:0] d, input logic r,
                        input logic ini, input string tag, output logic accepted);
        int          flen;
        int          st;
        int          p;
        logic        exp_rdy;
        logic        es, eb, ef;
        logic [19:0] w;
        flen = 22 * mb;
        while (m_word.size() > 0 && m_start[0] + flen < t) begin
            void'(m_acc.pop_front());
            void'(m_start.pop_front());
            void'(m_word.pop_front());
        end
        rst  = r;
        init = ini;
        din  = d;
        v1   = v && !sel4;
        v4   = v && sel4;
        #1;
        exp_rdy = !(r || ini) && (mcount() != 2);
        check({tag, ".in_ready"}, sel4 ? rdy4 : rdy1, exp_rdy);
        accepted = v && exp_rdy;
        if (r || ini) begin
            m_acc.delete();
            m_start.delete();
            m_word.delete();
            last_end = 0;
        end else if (accepted) begin
            st = (t + 2 > last_end) ? t + 2 : last_end;
            m_acc.push_back(t + 1);
            m_start.push_back(st);
            m_word.push_back(d);
            last_end = st + flen;
        end
        tick();
        es = 1'b0; eb = 1'b0; ef = 1'b0;
        for (int i = 0; i < m_word.size(); i++) begin
            if (m_acc[i] <= t && t < m_start[i] + flen) eb = 1'b1;
            if (m_start[i] <= t && t < m_start[i] + flen) begin
                w = m_word[i];
                p = (t - m_start[i]) / mb;
                if (p == 0)       es = 1'b1;
                else if (p <= 20) es = w[p-1];
                else              es = 1'b0;
                ef = (t == m_start[i] + flen - 1);
            end
        end
        check({tag, ".serial20"},   sel4 ? ser4  : ser1,  es);
        check({tag, ".busy"},       sel4 ? busy4 : busy1, eb);
        check({tag, ".frame_done"}, sel4 ? fd4   : fd1,   ef);
    endtask

    initial begin : stim
        logic        acc;
        logic [19:0] burst [4];
        int          a;
        int          got;
        rst = 1'b0; init = 1'b0; v1 = 1'b0; v4 = 1'b0; din = '0;

        // Reset held with a word offered: nothing accepted
        repeat (3) step(1'b1, 20'h12345, 1'b1, 1'b0, "reset", acc);
        step(1'b0, 20'h0, 1'b0, 1'b0, "reset_release", acc);

        // Single word
        step(1'b1, 20'hA5C3F, 1'b0, 1'b0, "single", acc);
        check("single.accepted", acc, 1'b1);
        repeat (25) step(1'b0, 20'h0, 1'b0, 1'b0, "single", acc);

        // Burst of 4 with valid held; word advances only on acceptance
        burst[0] = 20'h00001; burst[1] = 20'h80000;
        burst[2] = 20'hFFFFF; burst[3] = 20'h00000;
        got = 0;
        for (int i = 0; i < 200 && got < 4; i++) begin
            step(1'b1, burst[got], 1'b0, 1'b0, "burst", acc);
            if (acc) got++;
        end
        check("burst.all_accepted", got == 4, 1'b1);
        repeat (80) step(1'b0, 20'h0, 1'b0, 1'b0, "burst", acc);

        // Slow bit rate instance
        sel4 = 1'b1; mb = 4;
        step(1'b0, 20'h0, 1'b1, 1'b0, "bc4_reset", acc);
        step(1'b1, 20'h00001, 1'b0, 1'b0, "bc4", acc);
        repeat (95) step(1'b0, 20'h0, 1'b0, 1'b0, "bc4", acc);
        sel4 = 1'b0; mb = 1;
        step(1'b0, 20'h0, 1'b1, 1'b0, "bc1_reset", acc);

        // init during data bit 10 with one word queued
        step(1'b1, 20'h3C3C3, 1'b0, 1'b0, "init_mid", acc);
        a = t;
        step(1'b1, 20'h0F0F0, 1'b0, 1'b0, "init_mid", acc);
        while (t < a + 12) step(1'b0, 20'h0, 1'b0, 1'b0, "init_mid", acc);
        step(1'b0, 20'h0, 1'b0, 1'b1, "init_mid", acc);
        repeat (3) step(1'b0, 20'h0, 1'b0, 1'b0, "init_after", acc);
        step(1'b1, 20'h5A5A5, 1'b0, 1'b0, "init_after", acc);
        repeat (25) step(1'b0, 20'h0, 1'b0, 1'b0, "init_after", acc);

        // Push and pop on the same stop-end edge
        step(1'b1, 20'hCAFE1, 1'b0, 1'b0, "pushpop", acc);
        a = t;
        step(1'b1, 20'h13579, 1'b0, 1'b0, "pushpop", acc);
        while (t + 1 < a + 23) step(1'b0, 20'h0, 1'b0, 1'b0, "pushpop", acc);
        step(1'b1, 20'h2468A, 1'b0, 1'b0, "pushpop", acc);
        check("pushpop.accepted", acc, 1'b1);
        repeat (70) step(1'b0, 20'h0, 1'b0, 1'b0, "pushpop", acc);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) != 0, 20'($urandom), 1'b0,
                 ($urandom % 97) == 0, "random", acc);
        end
        repeat (70) step(1'b0, 20'h0, 1'b0, 1'b0, "drain", acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
